// File: rtl/dqn_fx_pkg.sv
// dqn_fx_pkg: shared fixed-point constants, FSM state type and
// saturating resize helper for the DQN forward-path layers.
package dqn_fx_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int FRAC_W_DEF = 10;

    localparam int ACT_LINEAR = 0;
    localparam int ACT_RELU   = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_FINISH,
        S_OUT
    } fsm_t;

    // Clamp a wide signed value into the range of a w-bit signed word.
    function automatic logic signed [63:0] sat_resize(
        input logic signed [63:0] v,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/fx_act_sat.sv
// fx_act_sat: per-neuron bias add, activation and saturation (combinational).
// Ports: i_acc accumulator, i_bias bias word, o_y saturated output word.
// Macro FWD_LAYER_LEAKY_EN: ReLU becomes leaky (negative z scaled by 1/8).
module fx_act_sat
    import dqn_fx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = 30,
    parameter int ACT    = ACT_RELU
) (
    input  logic signed [ACC_W-1:0]  i_acc,
    input  logic signed [DATA_W-1:0] i_bias,
    output logic        [DATA_W-1:0] o_y
);

    logic signed [63:0] w_z;
    logic signed [63:0] w_a;
    logic signed [63:0] w_s;
    logic               w_unused;

    always_comb begin
        w_z = {{(64-ACC_W){i_acc[ACC_W-1]}}, i_acc}
            + {{(64-DATA_W){i_bias[DATA_W-1]}}, i_bias};
        w_a = w_z;
        if (ACT == ACT_RELU && w_z < 0) begin
`ifdef FWD_LAYER_LEAKY_EN
            w_a = w_z >>> 3;
`else
            w_a = '0;
`endif
        end
        w_s = sat_resize(w_a, DATA_W);
    end

    assign o_y      = w_s[DATA_W-1:0];
    assign w_unused = ^w_s[63:DATA_W];

endmodule

// File: rtl/fwd_layer_mac.sv
// fwd_layer_mac: fully-connected layer engine; streams N_IN activations,
// MACs into N_OUT accumulators, then bias/activation/saturate per neuron.
// Ports: clk/rst (async active-high); in_* activation stream (valid/ready,
// in_last); wr_* weight/bias write port; out_* vector output (valid/ready);
// busy (not IDLE); err (length mismatch or rejected write pulse).
// Macro FWD_LAYER_LEAKY_EN: leaky ReLU in fx_act_sat.
module fwd_layer_mac
    import dqn_fx_pkg::*;
#(
    parameter int N_IN    = 9,
    parameter int N_OUT   = 5,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int FRAC_W  = FRAC_W_DEF,
    parameter int GUARD_W = 8,
    parameter int ACT     = ACT_RELU,
    localparam int AW     = $clog2(N_IN*N_OUT+N_OUT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  in_data,
    input  logic                      in_last,
    input  logic                      wr_en,
    input  logic        [AW-1:0]      wr_addr,
    input  logic signed [DATA_W-1:0]  wr_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_OUT*DATA_W-1:0]   out_data,
    output logic                      busy,
    output logic                      err
);

    localparam int ACC_W = 2*DATA_W - FRAC_W + GUARD_W;
    localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int NW    = N_IN*N_OUT + N_OUT;

    fsm_t                      r_state;
    logic [IW-1:0]             r_idx;
    logic signed [DATA_W-1:0]  r_w   [N_IN][N_OUT];
    logic signed [DATA_W-1:0]  r_b   [N_OUT];
    logic signed [ACC_W-1:0]   r_acc [N_OUT];
    logic [N_OUT*DATA_W-1:0]   r_out;
    logic                      r_out_valid;
    logic                      r_in_ready;
    logic                      r_err;

    logic                      w_take;
    logic                      w_wr_ok;
    logic                      w_at_end;
    logic [IW-1:0]             w_idx_n;
    logic [IW-1:0]             w_row;
    logic signed [2*DATA_W-1:0] w_p    [N_OUT];
    logic signed [ACC_W-1:0]   w_prod [N_OUT];
    logic [N_OUT*DATA_W-1:0]   w_y;

    assign busy      = (r_state != S_IDLE);
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out;
    assign err       = r_err;

    assign w_take   = in_valid && r_in_ready;
    assign w_wr_ok  = !busy && ({1'b0, wr_addr} < (AW+1)'(NW));
    assign w_idx_n  = r_idx + 1'b1;
    assign w_at_end = (w_idx_n == IW'(N_IN - 1));
    // First input always uses weight row 0; later ones the next index.
    assign w_row    = (r_state == S_IDLE) ? '0 : w_idx_n;

    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            w_p[j]    = r_w[w_row][j] * in_data;
            w_prod[j] = ACC_W'(w_p[j] >>> FRAC_W);
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
        fx_act_sat #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W),
            .ACT    (ACT)
        ) u_act_sat (
            .i_acc  (r_acc[j]),
            .i_bias (r_b[j]),
            .o_y    (w_y[j*DATA_W +: DATA_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_err       <= 1'b0;
            for (int j = 0; j < N_OUT; j++) begin
                r_acc[j] <= '0;
                r_b[j]   <= '0;
                for (int i = 0; i < N_IN; i++)
                    r_w[i][j] <= '0;
            end
        end else begin
            r_err <= 1'b0;

            if (wr_en) begin
                if (w_wr_ok) begin
                    for (int j = 0; j < N_OUT; j++) begin
                        if (wr_addr == AW'(N_IN*N_OUT + j))
                            r_b[j] <= wr_data;
                        for (int i = 0; i < N_IN; i++)
                            if (wr_addr == AW'(i*N_OUT + j))
                                r_w[i][j] <= wr_data;
                    end
                end else begin
                    r_err <= 1'b1;
                end
            end

            unique case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_take) begin
                        r_idx <= '0;
                        for (int j = 0; j < N_OUT; j++)
                            r_acc[j] <= w_prod[j];
                        if (N_IN == 1 || in_last) begin
                            r_state    <= S_FINISH;
                            r_in_ready <= 1'b0;
                            // Single-input layer needs in_last; longer ones must not see it yet.
                            if ((N_IN == 1) != in_last)
                                r_err <= 1'b1;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_take) begin
                        r_idx <= w_idx_n;
                        for (int j = 0; j < N_OUT; j++)
                            r_acc[j] <= r_acc[j] + w_prod[j];
                        if (w_at_end || in_last) begin
                            r_state    <= S_FINISH;
                            r_in_ready <= 1'b0;
                            if (w_at_end != in_last)
                                r_err <= 1'b1;
                        end
                    end
                end
                S_FINISH: begin
                    r_out       <= w_y;
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
